// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the three-master single-beat bus arbiter:
// FSM encoding, master indices and the default completion timeout.
package bus_arbiter_pkg;

    localparam int N_MASTERS   = 3;
    localparam int TIMEOUT_DEF = 15;

    localparam logic [1:0] M0_IDX   = 2'd0;
    localparam logic [1:0] M1_IDX   = 2'd1;
    localparam logic [1:0] M2_IDX   = 2'd2;
    // Master 2 counts as last-granted after reset so master 0 wins first.
    localparam logic [1:0] LAST_RST = M2_IDX;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx >= M2_IDX) ? M0_IDX : idx + 2'd1;
    endfunction

    function automatic logic [2:0] idx_onehot(input logic [1:0] idx);
        return 3'b001 << idx;
    endfunction

endpackage

// File: rtl/rib_rr_pick.sv
// Round-robin pick among three requesters: the search starts one past the
// last-granted index and wraps, the first active request found wins.
module rib_rr_pick
    import bus_arbiter_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic       valid,
    output logic [1:0] idx
);

    logic [1:0] cand;

    always_comb begin
        valid = 1'b0;
        idx   = last;
        cand  = last;
        for (int i = 0; i < N_MASTERS; i++) begin
            cand = rr_next(cand);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Three-master to one-slave single-beat bus arbiter with round-robin grant,
// back-to-back hand-over and a timeout that force-completes stuck transfers.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no transfer on the slave bus; bus_* hold their last value
//   ST_BUSY | granted request driven on bus_*, waiting for bus_ready
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_wraddr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_wraddr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,

    input  logic              m2_req,
    input  logic              m2_we,
    input  logic [ADDR_W-1:0] m2_wraddr,
    input  logic [DATA_W-1:0] m2_wdata,
    output logic              m2_ack,
    output logic [DATA_W-1:0] m2_rdata,
    output logic              m2_err,

    output logic              bus_valid,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_wraddr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ready,
    input  logic [DATA_W-1:0] bus_rdata,

    output logic              hold_flag
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    arb_state_t        state_q, state_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        last_q, last_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [2:0]        ack_q, ack_d;
    logic              err_q, err_d;

    logic [2:0]        req_vec;
    logic [2:0]        gnt_mask;
    logic [2:0]        pick_req;
    logic [1:0]        pick_last;
    logic [1:0]        pick_idx;
    logic              pick_valid;
    logic              busy;
    logic              timeout_hit;
    logic              complete;

    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign req_vec     = {m2_req, m1_req, m0_req};
    assign busy        = (state_q == ST_BUSY);
    assign timeout_hit = busy && !bus_ready && (cnt_q == TO_LAST);
    assign complete    = busy && (bus_ready || timeout_hit);

    // A master is out of the running while its ack is showing and, in the
    // completion cycle, the master being completed is excluded as well.
    assign gnt_mask  = complete ? idx_onehot(gnt_q) : 3'b000;
    assign pick_req  = req_vec & ~ack_q & ~gnt_mask;
    assign pick_last = busy ? gnt_q : last_q;

    rib_rr_pick u_rr_pick (
        .req   (pick_req),
        .last  (pick_last),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        sel_we    = m0_we;
        sel_addr  = m0_wraddr;
        sel_wdata = m0_wdata;
        case (pick_idx)
            M1_IDX: begin
                sel_we    = m1_we;
                sel_addr  = m1_wraddr;
                sel_wdata = m1_wdata;
            end
            M2_IDX: begin
                sel_we    = m2_we;
                sel_addr  = m2_wraddr;
                sel_wdata = m2_wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        bus_we_d = bus_we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        ack_d    = 3'b000;
        err_d    = 1'b0;

        if (complete) begin
            ack_d   = idx_onehot(gnt_q);
            err_d   = timeout_hit;
            rdata_d = timeout_hit ? '0 : bus_rdata;
            last_d  = gnt_q;
            cnt_d   = 8'd0;
            state_d = ST_IDLE;
        end else if (busy) begin
            cnt_d = cnt_q + 8'd1;
        end

        // Grant from IDLE, or hand straight over in the completion cycle.
        if ((!busy || complete) && pick_valid) begin
            state_d  = ST_BUSY;
            gnt_d    = pick_idx;
            cnt_d    = 8'd0;
            bus_we_d = sel_we;
            addr_d   = sel_addr;
            wdata_d  = sel_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            gnt_q    <= M0_IDX;
            last_q   <= LAST_RST;
            cnt_q    <= 8'd0;
            bus_we_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            ack_q    <= 3'b000;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            bus_we_q <= bus_we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
        end
    end

    assign bus_valid  = busy;
    assign bus_we     = bus_we_q;
    assign bus_wraddr = addr_q;
    assign bus_wdata  = wdata_q;

    assign m0_ack   = ack_q[M0_IDX];
    assign m1_ack   = ack_q[M1_IDX];
    assign m2_ack   = ack_q[M2_IDX];
    assign m0_err   = err_q & ack_q[M0_IDX];
    assign m1_err   = err_q & ack_q[M1_IDX];
    assign m2_err   = err_q & ack_q[M2_IDX];
    assign m0_rdata = ack_q[M0_IDX] ? rdata_q : '0;
    assign m1_rdata = ack_q[M1_IDX] ? rdata_q : '0;
    assign m2_rdata = ack_q[M2_IDX] ? rdata_q : '0;

    assign hold_flag = (m0_req & ~m0_ack) | (m1_req & ~m1_ack);

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: round-robin pick table, directed
// multi-cycle sequences and a randomized run against a transaction model.
module tb_bus_arbiter;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mreq [3];
    logic        mwe  [3];
    logic [31:0] maddr[3];
    logic [31:0] mdata[3];

    logic        m0_ack, m1_ack, m2_ack;
    logic        m0_err, m1_err, m2_err;
    logic [31:0] m0_rdata, m1_rdata, m2_rdata;
    logic        bus_valid, bus_we, bus_ready, hold_flag;
    logic [31:0] bus_wraddr, bus_wdata, bus_rdata;
    logic [2:0]  ack_v;

    logic [2:0]  pk_req;
    logic [1:0]  pk_last, pk_idx;
    logic        pk_valid;

    int checks = 0;
    int errors = 0;

    assign ack_v = {m2_ack, m1_ack, m0_ack};

    always #5 clk = ~clk;

    bus_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .m0_req     (mreq[0]),
        .m0_we      (mwe[0]),
        .m0_wraddr  (maddr[0]),
        .m0_wdata   (mdata[0]),
        .m0_ack     (m0_ack),
        .m0_rdata   (m0_rdata),
        .m0_err     (m0_err),
        .m1_req     (mreq[1]),
        .m1_we      (mwe[1]),
        .m1_wraddr  (maddr[1]),
        .m1_wdata   (mdata[1]),
        .m1_ack     (m1_ack),
        .m1_rdata   (m1_rdata),
        .m1_err     (m1_err),
        .m2_req     (mreq[2]),
        .m2_we      (mwe[2]),
        .m2_wraddr  (maddr[2]),
        .m2_wdata   (mdata[2]),
        .m2_ack     (m2_ack),
        .m2_rdata   (m2_rdata),
        .m2_err     (m2_err),
        .bus_valid  (bus_valid),
        .bus_we     (bus_we),
        .bus_wraddr (bus_wraddr),
        .bus_wdata  (bus_wdata),
        .bus_ready  (bus_ready),
        .bus_rdata  (bus_rdata),
        .hold_flag  (hold_flag)
    );

    rib_rr_pick u_pick (
        .req   (pk_req),
        .last  (pk_last),
        .valid (pk_valid),
        .idx   (pk_idx)
    );

    typedef struct {
        logic [2:0] req;
        logic [1:0] last;
        logic       valid;
        logic [1:0] idx;
    } rr_vec_t;

    rr_vec_t rr_tab[12];

    // transaction-level reference state
    bit          e_busy;
    int          e_owner, e_last, e_waited;
    logic [2:0]  e_ack;
    logic        e_err, e_done_we, e_we;
    logic [31:0] e_rdata, e_addr, e_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rdata_of(input int i);
        return (i == 0) ? m0_rdata : (i == 1) ? m1_rdata : m2_rdata;
    endfunction

    function automatic logic err_of(input int i);
        return (i == 0) ? m0_err : (i == 1) ? m1_err : m2_err;
    endfunction

    task automatic new_payload(input int i);
        mwe[i]   = 1'($urandom_range(1, 0));
        maddr[i] = $urandom;
        mdata[i] = $urandom;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        bus_ready = 1'b0;
        bus_rdata = 32'h0;
        for (int i = 0; i < 3; i++) mreq[i] = 1'b0;
        @(negedge clk);
        chk("rst_valid", bus_valid, 1'b0);
        chk("rst_we", bus_we, 1'b0);
        chk("rst_addr", bus_wraddr, 32'h0);
        chk("rst_wdata", bus_wdata, 32'h0);
        chk("rst_ack", ack_v, 3'b000);
        chk("rst_err", {m2_err, m1_err, m0_err}, 3'b000);
        chk("rst_rdata", {m2_rdata, m1_rdata, m0_rdata}, 96'h0);
        rst = 1'b0;
    endtask

    task automatic model_reset();
        e_busy = 0; e_owner = 0; e_last = 2; e_waited = 0;
        e_ack = 3'b000; e_err = 0; e_done_we = 0; e_rdata = 0;
        e_we = 0; e_addr = 0; e_data = 0;
    endtask

    // One clock of the reference: finish the owner's transfer on ready or
    // after TO waiting cycles, then hand the bus to the next requester
    // searching from one past the most recently completed master.
    task automatic model_step();
        bit         done;
        bit         found;
        int         j;
        logic [2:0] nack;
        done = 0;
        nack = 3'b000;
        if (e_busy) begin
            if (bus_ready) begin
                done = 1; e_err = 0; e_rdata = bus_rdata;
            end else if (e_waited + 1 >= TO) begin
                done = 1; e_err = 1; e_rdata = 0;
            end else begin
                e_waited++;
            end
        end
        if (done) begin
            nack[e_owner] = 1'b1;
            e_last        = e_owner;
            e_done_we     = e_we;
        end
        if (!e_busy || done) begin
            found = 0;
            for (int k = 1; k <= 3; k++) begin
                j = (e_last + k) % 3;
                if (!found && mreq[j] && !e_ack[j] && !(done && j == e_owner)) begin
                    found   = 1;
                    e_owner = j;
                    e_we    = mwe[j];
                    e_addr  = maddr[j];
                    e_data  = mdata[j];
                end
            end
            e_busy   = found;
            e_waited = 0;
        end
        e_ack = nack;
    endtask

    logic [2:0] exp_b[6];

    initial begin
        for (int i = 0; i < 3; i++) begin
            mreq[i] = 1'b0; mwe[i] = 1'b0; maddr[i] = 32'h0; mdata[i] = 32'h0;
        end
        bus_ready = 1'b0;
        bus_rdata = 32'h0;
        pk_req    = 3'b000;
        pk_last   = 2'd2;

        rr_tab[0]  = '{3'b000, 2'd2, 1'b0, 2'd0};
        rr_tab[1]  = '{3'b001, 2'd2, 1'b1, 2'd0};
        rr_tab[2]  = '{3'b111, 2'd2, 1'b1, 2'd0};
        rr_tab[3]  = '{3'b111, 2'd0, 1'b1, 2'd1};
        rr_tab[4]  = '{3'b111, 2'd1, 1'b1, 2'd2};
        rr_tab[5]  = '{3'b110, 2'd2, 1'b1, 2'd1};
        rr_tab[6]  = '{3'b100, 2'd0, 1'b1, 2'd2};
        rr_tab[7]  = '{3'b011, 2'd1, 1'b1, 2'd0};
        rr_tab[8]  = '{3'b101, 2'd0, 1'b1, 2'd2};
        rr_tab[9]  = '{3'b010, 2'd1, 1'b1, 2'd1};
        rr_tab[10] = '{3'b001, 2'd0, 1'b1, 2'd0};
        rr_tab[11] = '{3'b100, 2'd2, 1'b1, 2'd2};

        exp_b = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

        do_reset();

        for (int i = 0; i < 12; i++) begin
            pk_req  = rr_tab[i].req;
            pk_last = rr_tab[i].last;
            #1;
            chk("rr_valid", pk_valid, rr_tab[i].valid);
            if (rr_tab[i].valid) chk("rr_idx", pk_idx, rr_tab[i].idx);
        end

        // m0 and m1 together: m0 first, m1 handed over with no idle gap
        do_reset();
        mreq[0] = 1; mwe[0] = 1; maddr[0] = 32'h0000_0100; mdata[0] = 32'h1111_0000;
        mreq[1] = 1; mwe[1] = 0; maddr[1] = 32'h0000_0200; mdata[1] = 32'h2222_0000;
        bus_ready = 1;
        @(negedge clk);
        chk("A_valid1", bus_valid, 1'b1);
        chk("A_addr1", bus_wraddr, 32'h0000_0100);
        chk("A_we1", bus_we, 1'b1);
        chk("A_ack1", ack_v, 3'b000);
        @(negedge clk);
        chk("A_ack_m0", ack_v, 3'b001);
        chk("A_valid2", bus_valid, 1'b1);
        chk("A_addr2", bus_wraddr, 32'h0000_0200);
        mreq[0] = 0;
        @(negedge clk);
        chk("A_ack_m1", ack_v, 3'b010);
        chk("A_valid3", bus_valid, 1'b0);
        mreq[1] = 0;
        @(negedge clk);
        chk("A_idle", bus_valid, 1'b0);
        chk("A_idle_addr", bus_wraddr, 32'h0000_0200);

        // all three held: strict rotation, one ack per cycle
        do_reset();
        for (int i = 0; i < 3; i++) begin
            mreq[i] = 1; mwe[i] = 0; maddr[i] = 32'h10 * (i + 1); mdata[i] = 32'h0;
        end
        bus_ready = 1;
        @(negedge clk);
        chk("B_first", bus_wraddr, 32'h10);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("B_order", ack_v, exp_b[k]);
        end

        // m1 read with slave ready after three wait cycles
        do_reset();
        mreq[1] = 1; mwe[1] = 0; maddr[1] = 32'h0000_1004;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("C_wait", ack_v, 3'b000);
            chk("C_valid", bus_valid, 1'b1);
        end
        chk("C_addr", bus_wraddr, 32'h0000_1004);
        chk("C_we", bus_we, 1'b0);
        bus_ready = 1; bus_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("C_ack", ack_v, 3'b010);
        chk("C_rdata", m1_rdata, 32'hDEAD_BEEF);
        chk("C_err", m1_err, 1'b0);
        mreq[1] = 0; bus_ready = 0;

        // m2 write against a slave that never answers
        do_reset();
        mreq[2] = 1; mwe[2] = 1; maddr[2] = 32'h0000_3000; mdata[2] = 32'hCAFE_0003;
        bus_rdata = 32'h1234_5678;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            chk("D_valid", bus_valid, 1'b1);
            chk("D_noack", ack_v, 3'b000);
        end
        @(negedge clk);
        chk("D_ack", ack_v, 3'b100);
        chk("D_err", m2_err, 1'b1);
        chk("D_rdata", m2_rdata, 32'h0);
        chk("D_idle", bus_valid, 1'b0);
        mreq[2] = 0;
        @(negedge clk);
        chk("D_stay_idle", bus_valid, 1'b0);

        // reset in the second BUSY cycle of an m0 transfer
        do_reset();
        mreq[0] = 1; mwe[0] = 0; maddr[0] = 32'h0000_00A0;
        @(negedge clk);
        chk("E_valid1", bus_valid, 1'b1);
        @(negedge clk);
        rst = 1;
        #1;
        chk("E_valid_rst", bus_valid, 1'b0);
        chk("E_ack_rst", ack_v, 3'b000);
        #1;
        rst = 0;
        @(negedge clk);
        chk("E_regrant", bus_valid, 1'b1);
        chk("E_addr", bus_wraddr, 32'h0000_00A0);
        chk("E_noack", ack_v, 3'b000);
        bus_ready = 1;
        @(negedge clk);
        chk("E_ack", ack_v, 3'b001);
        mreq[0] = 0; bus_ready = 0;

        // hold_flag tracks an outstanding m0 request
        do_reset();
        mreq[0] = 1; maddr[0] = 32'h0000_0040;
        #1;
        chk("F_hold0", hold_flag, 1'b1);
        @(negedge clk);
        chk("F_hold1", hold_flag, 1'b1);
        @(negedge clk);
        chk("F_hold2", hold_flag, 1'b1);
        bus_ready = 1;
        @(negedge clk);
        chk("F_ack", ack_v, 3'b001);
        chk("F_hold_ack", hold_flag, 1'b0);
        mreq[0] = 0; bus_ready = 0;
        mreq[2] = 1;
        #1;
        chk("F_hold_m2", hold_flag, 1'b0);
        mreq[2] = 0;

        // randomized traffic against the reference
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            chk("rnd_valid", bus_valid, e_busy);
            chk("rnd_we", bus_we, e_we);
            chk("rnd_addr", bus_wraddr, e_addr);
            chk("rnd_wdata", bus_wdata, e_data);
            chk("rnd_ack", ack_v, e_ack);
            for (int i = 0; i < 3; i++) begin
                if (e_ack[i]) begin
                    chk("rnd_err", err_of(i), e_err);
                    if (e_err || !e_done_we) chk("rnd_rdata", rdata_of(i), e_rdata);
                end
            end
            for (int i = 0; i < 3; i++) begin
                if (mreq[i] && e_ack[i]) begin
                    if ($urandom_range(1, 0) == 1) new_payload(i);
                    else mreq[i] = 0;
                end else if (!mreq[i] && $urandom_range(2, 0) == 0) begin
                    mreq[i] = 1;
                    new_payload(i);
                end
            end
            bus_ready = ($urandom_range(99, 0) < ((cyc < 700) ? 50 : 4));
            bus_rdata = $urandom;
            #1;
            chk("rnd_hold", hold_flag,
                (mreq[0] & ~e_ack[0]) | (mreq[1] & ~e_ack[1]));
            model_step();
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
